// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : MEM/WB pipeline register and register-file write port owner.
//               Merges in-order results with a 1-entry long-latency buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              lat_valid,
    output logic              lat_ready,
    input  logic [ADDR_W-1:0] lat_wd,
    input  logic [DATA_W-1:0] lat_wdata,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_wd,
    output logic              stall_req
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic              r_p_wreg;
    logic [ADDR_W-1:0] r_p_wd;
    logic [DATA_W-1:0] r_p_wdata;

    logic              r_b_valid;
    logic [ADDR_W-1:0] r_b_wd;
    logic [DATA_W-1:0] r_b_wdata;

    logic [3:0]        r_cnt;

    logic              w_slot;
    logic              w_retire;
    logic              w_accept;

    // A pipeline write to register 0 leaves the port free for the buffer.
    assign w_slot    = r_p_wreg && (r_p_wd != '0);
    assign w_retire  = r_b_valid && !w_slot;
    assign lat_ready = !rst && !r_b_valid;
    assign w_accept  = lat_valid && lat_ready;

    always_ff @(posedge clk) begin
        if (rst || flush || stall) begin
            r_p_wreg  <= 1'b0;
            r_p_wd    <= '0;
            r_p_wdata <= '0;
        end else begin
            r_p_wreg  <= mem_wreg;
            r_p_wd    <= mem_wd;
            r_p_wdata <= mem_wdata;
        end
    end

    // Flush never touches the buffer: long-latency results are committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_valid <= 1'b0;
            r_b_wd    <= '0;
            r_b_wdata <= '0;
        end else if (w_retire) begin
            r_b_valid <= 1'b0;
        end else if (w_accept) begin
            r_b_valid <= 1'b1;
            r_b_wd    <= lat_wd;
            r_b_wdata <= lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !r_b_valid || w_retire) begin
            r_cnt <= 4'd0;
        end else if (w_slot && (r_cnt != c_starve_max)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_comb begin
        wb_we    = 1'b0;
        wb_waddr = '0;
        wb_wdata = '0;
        if (!rst) begin
            if (w_slot) begin
                wb_we    = 1'b1;
                wb_waddr = r_p_wd;
                wb_wdata = r_p_wdata;
            end else if (r_b_valid && (r_b_wd != '0)) begin
                wb_we    = 1'b1;
                wb_waddr = r_b_wd;
                wb_wdata = r_b_wdata;
            end
        end
    end

    assign pend_valid = !rst && r_b_valid;
    assign pend_wd    = (!rst && r_b_valid) ? r_b_wd : '0;
    assign stall_req  = !rst && r_b_valid && (r_cnt == c_starve_max);

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage: cycle model plus directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              mem_wreg;
    logic [ADDR_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_wdata;
    logic              lat_valid;
    logic              lat_ready;
    logic [ADDR_W-1:0] lat_wd;
    logic [DATA_W-1:0] lat_wdata;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_wd;
    logic              stall_req;

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .lat_valid  (lat_valid),
        .lat_ready  (lat_ready),
        .lat_wd     (lat_wd),
        .lat_wdata  (lat_wdata),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .pend_valid (pend_valid),
        .pend_wd    (pend_wd),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: what was last captured from MEM, what result is
    // waiting, and how many cycles it has been pushed aside by the pipeline.
    logic              m_pw    = 1'b0;
    logic [ADDR_W-1:0] m_pd    = '0;
    logic [DATA_W-1:0] m_pdata = '0;
    logic              m_bv    = 1'b0;
    logic [ADDR_W-1:0] m_bd    = '0;
    logic [DATA_W-1:0] m_bdata = '0;
    int                m_wait  = 0;

    function automatic logic pipe_owns_port();
        return m_pw && (m_pd != 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pw <= 1'b0; m_pd <= '0; m_pdata <= '0;
            m_bv <= 1'b0; m_bd <= '0; m_bdata <= '0;
            m_wait <= 0;
        end else begin
            if (flush || stall) begin
                m_pw <= 1'b0; m_pd <= '0; m_pdata <= '0;
            end else begin
                m_pw <= mem_wreg; m_pd <= mem_wd; m_pdata <= mem_wdata;
            end
            if (m_bv && !pipe_owns_port()) begin
                m_bv   <= 1'b0;
                m_wait <= 0;
            end else if (m_bv) begin
                m_wait <= (m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1;
            end else begin
                m_wait <= 0;
                if (lat_valid) begin
                    m_bv <= 1'b1; m_bd <= lat_wd; m_bdata <= lat_wdata;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        e_we = 1'b0; e_addr = '0; e_data = '0;
        if (!rst) begin
            if (pipe_owns_port()) begin
                e_we = 1'b1; e_addr = m_pd; e_data = m_pdata;
            end else if (m_bv && m_bd != 0) begin
                e_we = 1'b1; e_addr = m_bd; e_data = m_bdata;
            end
        end
        check("cyc_wb_we",      64'(wb_we),      64'(e_we));
        check("cyc_wb_waddr",   64'(wb_waddr),   64'(e_addr));
        check("cyc_wb_wdata",   64'(wb_wdata),   64'(e_data));
        check("cyc_lat_ready",  64'(lat_ready),  64'(!rst && !m_bv));
        check("cyc_pend_valid", 64'(pend_valid), 64'(!rst && m_bv));
        check("cyc_pend_wd",    64'(pend_wd),    64'((!rst && m_bv) ? m_bd : '0));
        check("cyc_stall_req",  64'(stall_req),  64'(!rst && m_bv && m_wait == STARVE_MAX));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
        lat_valid = 1'b0; lat_wd = '0; lat_wdata = '0;

        // Reset then idle
        step(); step();
        check("rst_we", 64'(wb_we), 64'd0);
        check("rst_lat_ready", 64'(lat_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_lat_ready", 64'(lat_ready), 64'd1);
        check("idle_pend_valid", 64'(pend_valid), 64'd0);
        check("idle_stall_req", 64'(stall_req), 64'd0);

        // Plain pipeline write, then a write to register 0
        mem_wreg = 1'b1; mem_wd = 5'd5; mem_wdata = 32'hDEADBEEF;
        step();
        mem_wreg = 1'b1; mem_wd = 5'd0; mem_wdata = 32'h55;
        check("pipe_we", 64'(wb_we), 64'd1);
        check("pipe_waddr", 64'(wb_waddr), 64'd5);
        check("pipe_wdata", 64'(wb_wdata), 64'hDEADBEEF);
        step();
        mem_wreg = 1'b0;
        check("pipe_r0_we", 64'(wb_we), 64'd0);
        step();

        // Free-slot retire
        lat_valid = 1'b1; lat_wd = 5'd9; lat_wdata = 32'h1234;
        step();
        lat_valid = 1'b0;
        check("free_we", 64'(wb_we), 64'd1);
        check("free_waddr", 64'(wb_waddr), 64'd9);
        check("free_wdata", 64'(wb_wdata), 64'h1234);
        check("free_pend_valid", 64'(pend_valid), 64'd1);
        check("free_pend_wd", 64'(pend_wd), 64'd9);
        check("free_lat_ready", 64'(lat_ready), 64'd0);
        step();
        check("free_after_pend", 64'(pend_valid), 64'd0);
        check("free_after_ready", 64'(lat_ready), 64'd1);

        // Long-latency result to register 0 is discarded
        lat_valid = 1'b1; lat_wd = 5'd0; lat_wdata = 32'h77;
        step();
        lat_valid = 1'b0;
        check("r0_buf_we", 64'(wb_we), 64'd0);
        check("r0_buf_pend", 64'(pend_valid), 64'd1);
        step();
        check("r0_buf_drop", 64'(pend_valid), 64'd0);

        // Starvation: pipeline writes 1..5 back to back while reg 7 waits
        lat_valid = 1'b1; lat_wd = 5'd7; lat_wdata = 32'h7777;
        mem_wreg = 1'b1; mem_wd = 5'd1; mem_wdata = 32'h101;
        step();
        lat_valid = 1'b0;
        check("starve_c1_waddr", 64'(wb_waddr), 64'd1);
        check("starve_c1_req", 64'(stall_req), 64'd0);
        for (int r = 2; r <= 4; r++) begin
            mem_wd = 5'(r); mem_wdata = 32'(r * 16'h101);
            step();
        end
        check("starve_c4_waddr", 64'(wb_waddr), 64'd4);
        check("starve_c4_req", 64'(stall_req), 64'd0);
        mem_wd = 5'd5; mem_wdata = 32'h505;
        step();
        check("starve_req", 64'(stall_req), 64'd1);
        check("starve_req_waddr", 64'(wb_waddr), 64'd5);
        stall = 1'b1; mem_wd = 5'd6;
        step();
        stall = 1'b0; mem_wreg = 1'b0;
        check("starve_retire_waddr", 64'(wb_waddr), 64'd7);
        check("starve_retire_wdata", 64'(wb_wdata), 64'h7777);
        step();
        check("starve_req_clear", 64'(stall_req), 64'd0);
        check("starve_pend_clear", 64'(pend_valid), 64'd0);

        // Flush leaves the buffer intact
        lat_valid = 1'b1; lat_wd = 5'd3; lat_wdata = 32'h3333;
        mem_wreg = 1'b1; mem_wd = 5'd10; mem_wdata = 32'hA0A;
        step();
        lat_valid = 1'b0;
        mem_wd = 5'd6; mem_wdata = 32'h666; flush = 1'b1;
        check("flush_pre_waddr", 64'(wb_waddr), 64'd10);
        check("flush_pre_pend", 64'(pend_valid), 64'd1);
        step();
        flush = 1'b0; mem_wreg = 1'b0;
        check("flush_retire_we", 64'(wb_we), 64'd1);
        check("flush_retire_waddr", 64'(wb_waddr), 64'd3);
        check("flush_retire_wdata", 64'(wb_wdata), 64'h3333);
        step();
        check("flush_after_pend", 64'(pend_valid), 64'd0);

        // Reset mid-operation drops the buffered result
        lat_valid = 1'b1; lat_wd = 5'd12; lat_wdata = 32'hC;
        mem_wreg = 1'b1; mem_wd = 5'd11; mem_wdata = 32'hB;
        step();
        lat_valid = 1'b0; mem_wreg = 1'b0; rst = 1'b1;
        #1;
        check("mrst_we", 64'(wb_we), 64'd0);
        check("mrst_pend", 64'(pend_valid), 64'd0);
        check("mrst_ready", 64'(lat_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("mrst_after_we", 64'(wb_we), 64'd0);
        check("mrst_after_pend", 64'(pend_valid), 64'd0);
        check("mrst_after_ready", 64'(lat_ready), 64'd1);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
